adder_operand_pipe: RTL and testbench
=====================================

Name: adder_operand_pipe

Overview:
Two-stage elastic pipeline around the team's 32-bit combinational adder (A, B, Cin -> S, Cout).
- Stage 1 registers operands from an upstream valid/ready source and drives them to the adder.
- Stage 2 captures the adder result and derives status flags, then presents it to a downstream valid/ready consumer.
- Turns the combinational adder into a registered, back-pressurable datapath unit with a completed-operation counter.

Parameters:
WIDTH, 32, operand/sum width (must match the adder instance)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream operand valid
in_ready  output  1  block can accept operands this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry in
add_a  output  WIDTH  to adder A
add_b  output  WIDTH  to adder B
add_cin  output  1  to adder Cin
add_s  input  WIDTH  from adder S
add_cout  input  1  from adder Cout
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  registered sum
out_cout  output  1  registered carry out (unsigned overflow)
out_ovf  output  1  signed two's-complement overflow
out_zero  output  1  out_sum == 0
ops_count  output  CNT_W  number of results handed off downstream

Behaviour:
- Reset (rst_n=0 at posedge): s1_valid, out_valid, add_a/b/cin, out_sum, out_cout, out_ovf, out_zero and ops_count all 0.
  - Reset takes priority over any handshake in the same cycle.
  - Any in-flight data is discarded.
- Handshakes: input accepted when in_valid && in_ready; output accepted when out_valid && out_ready.
- Ready logic (combinational):
  - s2_free = !out_valid || out_ready
  - in_ready = !s1_valid || s2_free
  - in_ready does not depend on in_valid.
  - in_ready = 1 in the first cycle after reset.
- Stage 1:
  - On input accept, add_a/add_b/add_cin <= in_a/in_b/in_cin and s1_valid <= 1.
  - Else if s2_free, s1_valid <= 0; operand registers hold.
  - add_* change only on input accept.
- Stage 2:
  - When s1_valid && s2_free:
    - out_sum <= add_s; out_cout <= add_cout; out_zero <= (add_s == 0).
    - out_ovf <= (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]).
    - out_valid <= 1.
  - Else if out_ready, out_valid <= 0; data regs hold.
- Latency: input accepted at edge N -> out_valid high after edge N+1. Throughput is 1 op/cycle with out_ready held high.
- Backpressure:
  - While out_valid && !out_ready, out_sum/out_cout/out_ovf/out_zero are held stable.
  - Stage 1 may still fill; once both stages are full, in_ready = 0.
  - No result is lost or duplicated.
- Simultaneous events: in the same cycle, an output accept, a stage1->stage2 move and an input accept must all occur (full-rate streaming).
- ops_count increments by 1 per output accept and saturates at all-ones (no wrap).
- Cin participates in out_ovf only through add_s.
- Example: 0x7FFFFFFF + 0 with cin=1 -> ovf = 1.

Test Plan:
- Reset, then idle:
  - in_ready = 1, out_valid = 0, all outputs 0, ops_count = 0.
- Single op a=FFFFFFFF, b=00000001, cin=0, out_ready=1:
  - out_valid exactly 2 edges after accept.
  - sum = 00000000, cout = 1, ovf = 0, zero = 1, ops_count = 1.
- a=7FFFFFFF, b=00000001 -> sum = 80000000, cout = 0, ovf = 1.
- a=80000000, b=FFFFFFFF -> sum = 7FFFFFFF, cout = 1, ovf = 1.
- Streaming: 4 back-to-back ops (5+(-3), 7+A, (-4)+(-8), 0+0) with out_ready=1:
  - results 00000002, 00000011, FFFFFFF4, 00000000 on 4 consecutive cycles.
  - in_ready stays 1; ops_count = 4.
- Stall: out_ready=0 while offering 3 ops:
  - first two accepted, then in_ready = 0 and out_sum is held.
  - Raising out_ready drains results in order, then the third op is accepted; ops_count = 3.
- Reset asserted while both stages are full:
  - next cycle out_valid = 0, in_ready = 1, ops_count = 0.
  - No stale result appears afterwards.

Source files
------------

// File: rtl/adder_operand_pipe.sv
// Two-stage elastic pipeline around an external 32-bit combinational adder.
// Stage 1 holds the operands that drive the adder; stage 2 holds the result, flags and a handoff count.
module adder_operand_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [CNT_W-1:0] ops_count
);

  // Valid/ready: a transfer occurs on a rising edge where valid && ready are both high;
  // the source holds its data stable while valid && !ready, and ready never looks at valid.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s2_free;
  logic in_fire;
  logic out_fire;
  logic s1_move;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign s1_move  = s1_valid_q && s2_free;

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    if (in_fire) begin
      a_d        = in_a;
      b_d        = in_b;
      cin_d      = in_cin;
      s1_valid_d = 1'b1;
    end else if (s2_free) begin
      s1_valid_d = 1'b0;
    end
  end

  // Signed overflow: operands agree in sign but the sum does not; carry-in only acts through add_s.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (s1_move) begin
      sum_d       = add_s;
      cout_d      = add_cout;
      zero_d      = (add_s == '0);
      ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[WIDTH-1] != a_q[WIDTH-1]);
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      cnt_q       <= cnt_d;
    end
  end

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign ops_count = cnt_q;

endmodule

// File: tb/tb_adder_operand_pipe.sv
// Bench for adder_operand_pipe: behavioural adder, arithmetic reference model,
// negedge scoreboard with expected queue, and directed plus randomized scenarios.
module tb_adder_operand_pipe;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a      = '0;
  logic [W-1:0]  in_b      = '0;
  logic          in_cin    = 1'b0;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          out_zero;
  logic [CW-1:0] ops_count;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit started      = 1'b0;

  logic [W+2:0] exp_q[$];
  int           exp_ops    = 0;
  logic         prev_stall = 1'b0;
  logic [W+2:0] prev_res   = '0;

  adder_operand_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .ops_count(ops_count)
  );

  // The team's combinational adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  // Reference: packed {cout, ovf, zero, sum} from plain unsigned and signed arithmetic
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [63:0] ua;
    longint      sa;
    logic [W-1:0] s;
    logic         v;
    ua = {32'd0, a} + {32'd0, b} + {63'd0, cin};
    sa = longint'($signed(a)) + longint'($signed(b)) + longint'({63'd0, cin});
    s  = ua[W-1:0];
    v  = (sa > SMAX) || (sa < SMIN);
    return {ua[W], v, (s == '0), s};
  endfunction

  // Scoreboard: handshakes seen at negedge are the ones taken at the following posedge
  always @(negedge clk) begin
    logic [W+2:0] got;
    logic [W+2:0] exp_v;
    if (started) begin
      if (!rst_n) begin
        exp_q.delete();
        exp_ops    = 0;
        prev_stall = 1'b0;
      end else begin
        got = {out_cout, out_ovf, out_zero, out_sum};
        n_compared++;
        if (ops_count !== CW'(exp_ops)) begin
          n_mismatched++;
          $display("FAIL sb_ops_count: got %0d expected %0d", ops_count, exp_ops);
        end
        if (prev_stall) begin
          n_compared++;
          if (got !== prev_res) begin
            n_mismatched++;
            $display("FAIL sb_hold: got %h expected held %h", got, prev_res);
          end
        end
        if (out_valid && out_ready) begin
          n_compared++;
          if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("FAIL sb_unexpected: got %h expected no result", got);
          end else begin
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin
              n_mismatched++;
              $display("FAIL sb_result: got %h expected %h", got, exp_v);
            end
          end
          if (exp_ops < (1 << CW) - 1) exp_ops++;
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin));
        prev_stall = out_valid && !out_ready;
        prev_res   = got;
      end
    end
  end

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    started = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge with in_valid still high
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output int waited);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 60) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waited);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_hs: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    n_compared++;
    if ({add_a, add_b, add_cin} !== '0) begin
      n_mismatched++;
      $display("FAIL reset_operands: got %h %h %b expected zeros", add_a, add_b, add_cin);
    end
    n_compared++;
    if ({out_sum, out_cout, out_ovf, out_zero} !== '0 || ops_count !== '0) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got sum=%h c=%b v=%b z=%b cnt=%0d expected zeros",
               out_sum, out_cout, out_ovf, out_zero, ops_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int w;
    apply_reset();
    out_ready = 1'b1;
    send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, w);
    drive_idle();
    n_compared++;
    if (w != 0) begin
      n_mismatched++;
      $display("FAIL single_ready: got wait %0d expected 0", w);
    end
    @(negedge clk);
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL single_early: got out_valid=%b expected 0", out_valid);
    end
    @(negedge clk);
    n_compared++;
    if ({out_valid, out_cout, out_ovf, out_zero, out_sum} !== {4'b1101, 32'h0}) begin
      n_mismatched++;
      $display("FAIL single_result: got v=%b c=%b o=%b z=%b sum=%h expected 1 1 0 1 00000000",
               out_valid, out_cout, out_ovf, out_zero, out_sum);
    end
    @(negedge clk);
    n_compared++;
    if (ops_count !== CW'(1) || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL single_count: got cnt=%0d out_valid=%b expected 1/0", ops_count, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta[4];
    logic [W-1:0] tb[4];
    logic         tc[4];
    logic [W+2:0] te[4];
    int w;
    int t;
    ta[0] = 32'h7FFF_FFFF; tb[0] = 32'h0000_0001; tc[0] = 1'b0; te[0] = {3'b010, 32'h8000_0000};
    ta[1] = 32'h8000_0000; tb[1] = 32'hFFFF_FFFF; tc[1] = 1'b0; te[1] = {3'b110, 32'h7FFF_FFFF};
    ta[2] = 32'h7FFF_FFFF; tb[2] = 32'h0000_0000; tc[2] = 1'b1; te[2] = {3'b010, 32'h8000_0000};
    ta[3] = 32'hFFFF_FFFF; tb[3] = 32'hFFFF_FFFF; tc[3] = 1'b1; te[3] = {3'b100, 32'hFFFF_FFFF};
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_op(ta[i], tb[i], tc[i], w);
      drive_idle();
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 10) begin
        t++;
        @(negedge clk);
      end
      n_compared++;
      if (!out_valid) begin
        n_mismatched++;
        $display("FAIL ovf_timeout_%0d: got no out_valid expected a result", i);
      end else if ({out_cout, out_ovf, out_zero, out_sum} !== te[i]) begin
        n_mismatched++;
        $display("FAIL ovf_%0d: got %h expected %h", i,
                 {out_cout, out_ovf, out_zero, out_sum}, te[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sa[4];
    logic [W-1:0] sb[4];
    logic [W-1:0] se[4];
    int wsum;
    sa[0] = 32'd5;          sb[0] = 32'hFFFF_FFFD; se[0] = 32'h0000_0002;
    sa[1] = 32'd7;          sb[1] = 32'h0000_000A; se[1] = 32'h0000_0011;
    sa[2] = 32'hFFFF_FFFC;  sb[2] = 32'hFFFF_FFF8; se[2] = 32'hFFFF_FFF4;
    sa[3] = 32'd0;          sb[3] = 32'd0;         se[3] = 32'h0000_0000;
    wsum = 0;
    apply_reset();
    out_ready = 1'b1;
    fork
      begin
        int w;
        for (int i = 0; i < 4; i++) begin
          send_op(sa[i], sb[i], 1'b0, w);
          wsum += w;
        end
        drive_idle();
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 10) begin
          t++;
          @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          n_compared++;
          if (out_valid !== 1'b1 || out_sum !== se[k]) begin
            n_mismatched++;
            $display("FAIL b2b_%0d: got v=%b sum=%h expected v=1 sum=%h", k, out_valid, out_sum, se[k]);
          end
        end
      end
    join
    n_compared++;
    if (wsum != 0) begin
      n_mismatched++;
      $display("FAIL b2b_in_ready: got %0d stalled cycles expected 0", wsum);
    end
    @(negedge clk);
    n_compared++;
    if (ops_count !== CW'(4) || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_count: got cnt=%0d out_valid=%b expected 4/0", ops_count, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    logic [W-1:0] sa[3];
    logic [W-1:0] sb[3];
    logic         sc[3];
    logic [W+2:0] se[3];
    int ws[3];
    int k;
    for (int i = 0; i < 3; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      sc[i] = 1'($urandom_range(0, 1));
      se[i] = model(sa[i], sb[i], sc[i]);
    end
    apply_reset();
    out_ready = 1'b0;
    k = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) send_op(sa[i], sb[i], sc[i], ws[i]);
        drive_idle();
      end
      begin
        repeat (5) @(negedge clk);
        n_compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== se[0][W-1:0]) begin
          n_mismatched++;
          $display("FAIL stall_full: got rdy=%b v=%b sum=%h expected 0 1 %h",
                   in_ready, out_valid, out_sum, se[0][W-1:0]);
        end
        repeat (3) @(negedge clk);
        n_compared++;
        if (out_sum !== se[0][W-1:0] || in_ready !== 1'b0) begin
          n_mismatched++;
          $display("FAIL stall_hold: got sum=%h rdy=%b expected %h 0", out_sum, in_ready, se[0][W-1:0]);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && k < 3; t++) begin
          @(negedge clk);
          if (out_valid) begin
            n_compared++;
            if ({out_cout, out_ovf, out_zero, out_sum} !== se[k]) begin
              n_mismatched++;
              $display("FAIL stall_drain_%0d: got %h expected %h", k,
                       {out_cout, out_ovf, out_zero, out_sum}, se[k]);
            end
            k++;
          end
        end
      end
    join
    n_compared++;
    if (k != 3 || ws[2] == 0) begin
      n_mismatched++;
      $display("FAIL stall_order: got %0d results third_wait=%0d expected 3 and nonzero", k, ws[2]);
    end
    @(negedge clk);
    n_compared++;
    if (ops_count !== CW'(3)) begin
      n_mismatched++;
      $display("FAIL stall_count: got %0d expected 3", ops_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight();
    int w;
    apply_reset();
    out_ready = 1'b0;
    send_op($urandom, $urandom, 1'b0, w);
    send_op($urandom, $urandom, 1'b1, w);
    drive_idle();
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL midrst_full: got rdy=%b v=%b expected 0 1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ops_count !== '0 || out_sum !== '0) begin
      n_mismatched++;
      $display("FAIL midrst_clear: got v=%b rdy=%b cnt=%0d sum=%h expected 0 1 0 0",
               out_valid, in_ready, ops_count, out_sum);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_compared++;
      if (out_valid !== 1'b0) begin
        n_mismatched++;
        $display("FAIL midrst_stale_%0d: got out_valid=%b expected 0", i, out_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [W-1:0] corners[4];
    int  sent;
    int  cyc;
    int  t;
    logic acc;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h7FFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF;
    apply_reset();
    sent = 0;
    cyc  = 0;
    while (sent < 300 && cyc < 3000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
      cyc++;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0) && (sent < 300);
        in_a     = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        in_b     = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        in_cin   = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drive_idle();
    out_ready = 1'b1;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && t < 20) begin
      t++;
      @(negedge clk);
    end
    n_compared++;
    if (sent != 300 || exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL random_drain: got sent=%0d pending=%0d expected 300 0", sent, exp_q.size());
    end
    n_compared++;
    if (ops_count !== {CW{1'b1}}) begin
      n_mismatched++;
      $display("FAIL random_saturate: got %0d expected %0d", ops_count, (1 << CW) - 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
